// File: rtl/clk_div_multi_prog.sv
// Multi-channel programmable clock divider: per-channel 50%-duty square outputs,
// rising-edge ticks and glitch-free half-period reloads applied at phase wraps.
module clk_div_multi_prog #(
  parameter  int          NUM_CH   = 4,
  parameter  int          CNT_W    = 26,
  parameter  int unsigned DEF_HALF = 24999999,
  localparam int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              wr_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [CNT_W-1:0]  wr_half_i,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] pend_o
);

  localparam logic [CNT_W-1:0] DEF_HALF_W = CNT_W'(DEF_HALF);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] nxt_q, nxt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             wr_hit;

    // Out-of-range channel numbers never match any channel, so they are ignored.
    assign wr_hit = wr_i && (wr_ch_i == CH_W'(gi));

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        cnt_q  <= '0;
        act_q  <= DEF_HALF_W;
        nxt_q  <= DEF_HALF_W;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        nxt_q  <= nxt_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
        pend_q <= pend_d;
      end
    end

    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      nxt_d  = nxt_q;
      clk_d  = clk_q;
      tick_d = 1'b0;
      pend_d = pend_q;
      if (!en_i[gi]) begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        pend_d = 1'b0;
        if (pend_q) begin
          act_d = nxt_q;
        end
        // An idle channel has no phase to protect, so a write lands immediately.
        if (wr_hit) begin
          act_d = wr_half_i;
          nxt_d = wr_half_i;
        end
      end else begin
        if (cnt_q == act_q) begin
          cnt_d  = '0;
          clk_d  = ~clk_q;
          tick_d = ~clk_q;
          if (pend_q) begin
            act_d  = nxt_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A write on a wrap cycle stays pending for the following wrap.
        if (wr_hit) begin
          nxt_d  = wr_half_i;
          pend_d = 1'b1;
        end
      end
    end

    assign clk_o[gi]  = clk_q;
    assign tick_o[gi] = tick_q;
    assign pend_o[gi] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_multi_prog.sv
// Directed bench for clk_div_multi_prog: a timestamp-based phase model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_clk_div_multi_prog;
  localparam int NCH = 3;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [NCH-1:0] en_i;
  logic           wr_i;
  logic [1:0]     wr_ch_i;
  logic [7:0]     wr_half_i;
  logic [NCH-1:0] clk_o, tick_o, pend_o;

  int checks = 0;
  int failures = 0;

  // Model: each running channel knows the absolute cycle on which its phase ends.
  int cyc;
  int m_half[NCH], m_nxt[NCH], m_end[NCH];
  bit m_run[NCH], m_lvl[NCH], m_tick[NCH], m_pend[NCH];

  clk_div_multi_prog #(.NUM_CH(NCH), .CNT_W(8), .DEF_HALF(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .wr_i(wr_i), .wr_ch_i(wr_ch_i),
    .wr_half_i(wr_half_i), .clk_o(clk_o), .tick_o(tick_o), .pend_o(pend_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int c = 0; c < NCH; c++) begin
      m_half[c] = 3; m_nxt[c] = 3; m_end[c] = 0;
      m_run[c] = 0; m_lvl[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
    end
  endtask

  task automatic model_step(input logic [NCH-1:0] en, input logic w, input logic [1:0] ch,
                            input logic [7:0] hv);
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      bit hit;
      hit = w && (int'(ch) == c);
      m_tick[c] = 0;
      if (!en[c]) begin
        m_run[c] = 0;
        m_lvl[c] = 0;
        if (m_pend[c]) m_half[c] = m_nxt[c];
        m_pend[c] = 0;
        if (hit) begin m_half[c] = hv; m_nxt[c] = hv; end
      end else begin
        if (!m_run[c]) begin
          m_run[c] = 1;
          m_end[c] = cyc + m_half[c];
        end
        if (cyc == m_end[c]) begin
          m_lvl[c]  = !m_lvl[c];
          m_tick[c] = m_lvl[c];
          if (m_pend[c]) begin m_half[c] = m_nxt[c]; m_pend[c] = 0; end
          m_end[c] = cyc + 1 + m_half[c];
        end
        if (hit) begin m_nxt[c] = hv; m_pend[c] = 1; end
      end
    end
  endtask

  task automatic compare();
    logic [NCH-1:0] ec, et, ep;
    for (int c = 0; c < NCH; c++) begin
      ec[c] = m_lvl[c]; et[c] = m_tick[c]; ep[c] = m_pend[c];
    end
    check("model_clk_o", 32'(clk_o), 32'(ec));
    check("model_tick_o", 32'(tick_o), 32'(et));
    check("model_pend_o", 32'(pend_o), 32'(ep));
  endtask

  // One clock cycle with the given inputs; called at posedge+1.
  task automatic step(input logic [NCH-1:0] en, input logic w = 0, input logic [1:0] ch = 0,
                      input logic [7:0] hv = 0);
    en_i = en; wr_i = w; wr_ch_i = ch; wr_half_i = hv;
    @(posedge clk_i); #1;
    model_step(en, w, ch, hv);
    compare();
    wr_i = 0;
  endtask

  // Steps with all channels enabled until clk_o[c] changes; returns steps taken.
  task automatic phase_len(input int c, output int n);
    logic p;
    p = clk_o[c];
    n = 0;
    while (clk_o[c] == p && n < 100) begin
      step(3'b111);
      n++;
    end
  endtask

  task automatic sync_fail(input string name);
    failures++;
    $display("FAIL %s: sync condition not reached", name);
  endtask

  initial begin
    int last, iv, n, k;
    rst_i = 0; en_i = 0; wr_i = 0; wr_ch_i = 0; wr_half_i = 0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1;
    check("reset_clk_o", 32'(clk_o), 0);
    check("reset_tick_o", 32'(tick_o), 0);
    check("reset_pend_o", 32'(pend_o), 0);

    // T1: default half=3, first rise on the 4th enabled cycle, period 8
    for (int i = 1; i <= 3; i++) begin
      step(3'b111);
      check("t1_low_before_rise", 32'(clk_o), 0);
    end
    step(3'b111);
    check("t1_first_rise_clk", 32'(clk_o), 32'h7);
    check("t1_first_rise_tick", 32'(tick_o), 32'h7);
    last = 4; iv = 0;
    for (int i = 5; i <= 20; i++) begin
      step(3'b111);
      if (tick_o[0]) begin iv = i - last; last = i; end
    end
    check("t1_tick_period", 32'(iv), 8);

    // T2: disabled write of half=0 applies directly, then divide-by-2
    step(3'b110, 1, 0, 8'd0);
    check("t2_no_pend", 32'(pend_o[0]), 0);
    step(3'b111);
    check("t2_clk_c1", 32'(clk_o[0]), 1);
    check("t2_tick_c1", 32'(tick_o[0]), 1);
    step(3'b111);
    check("t2_clk_c2", 32'(clk_o[0]), 0);
    check("t2_tick_c2", 32'(tick_o[0]), 0);
    step(3'b111);
    check("t2_clk_c3", 32'(clk_o[0]), 1);
    check("t2_tick_c3", 32'(tick_o[0]), 1);

    // T3: mid-phase write to ch1, current phase finishes at old length
    for (k = 0; k < 20 && m_end[1] != cyc + 3; k++) step(3'b111);
    if (m_end[1] != cyc + 3) sync_fail("t3_sync");
    step(3'b111, 1, 1, 8'd5);
    check("t3_pend_set", 32'(pend_o[1]), 1);
    n = 0;
    while (pend_o[1] && n < 20) begin step(3'b111); n++; end
    check("t3_steps_to_apply", 32'(n), 2);
    phase_len(1, n);
    check("t3_new_phase", 32'(n), 6);

    // T4: write on the wrap cycle waits for the following wrap
    for (k = 0; k < 20 && m_end[1] != cyc + 1; k++) step(3'b111);
    if (m_end[1] != cyc + 1) sync_fail("t4_sync");
    step(3'b111, 1, 1, 8'd3);
    check("t4_pend_set", 32'(pend_o[1]), 1);
    phase_len(1, n);
    check("t4_old_phase", 32'(n), 6);
    check("t4_pend_clear", 32'(pend_o[1]), 0);
    phase_len(1, n);
    check("t4_new_phase", 32'(n), 4);

    // T5: drop en[0] mid-high, out-of-range write, re-enable
    step(3'b111, 1, 0, 8'd3);
    for (k = 0; k < 40 && !(clk_o[0] && m_end[0] >= cyc + 3); k++) step(3'b111);
    if (!(clk_o[0] && m_end[0] >= cyc + 3)) sync_fail("t5_sync");
    step(3'b110);
    check("t5_drop_clk", 32'(clk_o[0]), 0);
    step(3'b110, 1, 2'd3, 8'h55);
    check("t5_oob_pend", 32'(pend_o), 0);
    for (int i = 1; i <= 3; i++) begin
      step(3'b111);
      check("t5_reen_low", 32'(clk_o[0]), 0);
    end
    step(3'b111);
    check("t5_reen_rise", 32'(clk_o[0]), 1);

    // T6: asynchronous reset mid-phase with a write pending
    step(3'b111, 1, 1, 8'd9);
    check("t6_pend_before", 32'(pend_o[1]), 1);
    #3 rst_i = 0;
    #1;
    check("t6_async_clk_o", 32'(clk_o), 0);
    check("t6_async_tick_o", 32'(tick_o), 0);
    check("t6_async_pend_o", 32'(pend_o), 0);
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 1;
    for (int i = 1; i <= 3; i++) step(3'b111);
    step(3'b111);
    check("t6_first_rise", 32'(clk_o), 32'h7);
    phase_len(1, n);
    check("t6_def_phase", 32'(n), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
